// File: rtl/jt12_timer_flags_if.sv
// Register-side bundle between the CPU register file and the Timer A/B flag stage.
// The master drives reload values, run levels, IRQ enables, flag clears and write strobes.
interface jt12_timer_flags_if;
  logic [9:0] value_A;
  logic [7:0] value_B;
  logic       load_A;
  logic       load_B;
  logic       enable_irq_A;
  logic       enable_irq_B;
  logic       clr_flag_A;
  logic       clr_flag_B;
  logic       write;
  logic       flag_A;
  logic       flag_B;
  logic       overflow_A;
  logic       busy;
  logic       irq_n;

  modport master (
    output value_A, value_B, load_A, load_B, enable_irq_A, enable_irq_B,
           clr_flag_A, clr_flag_B, write,
    input  flag_A, flag_B, overflow_A, busy, irq_n
  );

  modport slave (
    input  value_A, value_B, load_A, load_B, enable_irq_A, enable_irq_B,
           clr_flag_A, clr_flag_B, write,
    output flag_A, flag_B, overflow_A, busy, irq_n
  );
endinterface

// File: rtl/jt12_timer_flags.sv
// Timer A/B stage producing flag_A, flag_B, overflow_A (CSM key-on), busy and irq_n.
// Optional write-busy generator is enabled by defining JT12_TIMER_BUSY_EN.
module jt12_timer_flags #(
  parameter int TB_DIV      = 16,
  parameter int BUSY_CYCLES = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cen,
  input  logic                 zero,
  jt12_timer_flags_if.slave    bus
);

  localparam int PW = (TB_DIV > 1) ? $clog2(TB_DIV) : 1;

  logic [9:0]    cnt_a_r;
  logic [9:0]    cnt_a_nxt_s;
  logic [7:0]    cnt_b_r;
  logic [7:0]    cnt_b_nxt_s;
  logic [PW-1:0] presc_r;
  logic [PW-1:0] presc_nxt_s;
  logic          load_a_prev_r;
  logic          load_b_prev_r;
  logic          flag_a_r;
  logic          flag_a_nxt_s;
  logic          flag_b_r;
  logic          flag_b_nxt_s;
  logic          ovf_a_r;
  logic          irq_n_r;
  logic          load_a_edge_s;
  logic          load_b_edge_s;
  logic          tick_a_s;
  logic          tick_b_s;
  logic          b_tick_s;
  logic          ovf_a_s;
  logic          ovf_b_s;

  // Timer A next state: a load edge reloads without counting
  always_comb begin
    load_a_edge_s = bus.load_A & ~load_a_prev_r;
    tick_a_s      = bus.load_A & zero & ~load_a_edge_s;
    ovf_a_s       = tick_a_s & (cnt_a_r == 10'd1023);
    if (load_a_edge_s) begin
      cnt_a_nxt_s = bus.value_A;
    end else if (ovf_a_s) begin
      cnt_a_nxt_s = bus.value_A;
    end else if (tick_a_s) begin
      cnt_a_nxt_s = cnt_a_r + 10'd1;
    end else begin
      cnt_a_nxt_s = cnt_a_r;
    end
    // Set beats clear so an overflow is never lost
    if (ovf_a_s & bus.enable_irq_A) begin
      flag_a_nxt_s = 1'b1;
    end else if (bus.clr_flag_A) begin
      flag_a_nxt_s = 1'b0;
    end else begin
      flag_a_nxt_s = flag_a_r;
    end
  end

  // Free-running Timer B prescaler, independent of load_B
  always_comb begin
    if (zero) begin
      presc_nxt_s = presc_r + PW'(1);
    end else begin
      presc_nxt_s = presc_r;
    end
    b_tick_s = zero & (presc_r == PW'(TB_DIV - 1));
  end

  // Timer B next state, ticked once per TB_DIV samples
  always_comb begin
    load_b_edge_s = bus.load_B & ~load_b_prev_r;
    tick_b_s      = bus.load_B & b_tick_s & ~load_b_edge_s;
    ovf_b_s       = tick_b_s & (cnt_b_r == 8'd255);
    if (load_b_edge_s) begin
      cnt_b_nxt_s = bus.value_B;
    end else if (ovf_b_s) begin
      cnt_b_nxt_s = bus.value_B;
    end else if (tick_b_s) begin
      cnt_b_nxt_s = cnt_b_r + 8'd1;
    end else begin
      cnt_b_nxt_s = cnt_b_r;
    end
    if (ovf_b_s & bus.enable_irq_B) begin
      flag_b_nxt_s = 1'b1;
    end else if (bus.clr_flag_B) begin
      flag_b_nxt_s = 1'b0;
    end else begin
      flag_b_nxt_s = flag_b_r;
    end
  end

  // Timer state registers; everything holds while cen is low
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_a_r       <= 10'd0;
      cnt_b_r       <= 8'd0;
      presc_r       <= '0;
      load_a_prev_r <= 1'b0;
      load_b_prev_r <= 1'b0;
      flag_a_r      <= 1'b0;
      flag_b_r      <= 1'b0;
      ovf_a_r       <= 1'b0;
      irq_n_r       <= 1'b1;
    end else if (cen) begin
      cnt_a_r       <= cnt_a_nxt_s;
      cnt_b_r       <= cnt_b_nxt_s;
      presc_r       <= presc_nxt_s;
      load_a_prev_r <= bus.load_A;
      load_b_prev_r <= bus.load_B;
      flag_a_r      <= flag_a_nxt_s;
      flag_b_r      <= flag_b_nxt_s;
      ovf_a_r       <= ovf_a_s;
      irq_n_r       <= ~(flag_a_r | flag_b_r);
    end else begin
      cnt_a_r       <= cnt_a_r;
      cnt_b_r       <= cnt_b_r;
      presc_r       <= presc_r;
      load_a_prev_r <= load_a_prev_r;
      load_b_prev_r <= load_b_prev_r;
      flag_a_r      <= flag_a_r;
      flag_b_r      <= flag_b_r;
      ovf_a_r       <= ovf_a_r;
      irq_n_r       <= irq_n_r;
    end
  end

  assign bus.flag_A     = flag_a_r;
  assign bus.flag_B     = flag_b_r;
  assign bus.overflow_A = ovf_a_r;
  assign bus.irq_n      = irq_n_r;

`ifdef JT12_TIMER_BUSY_EN
  localparam int BW = (BUSY_CYCLES > 1) ? $clog2(BUSY_CYCLES) : 1;

  logic [BW-1:0] busy_cnt_r;
  logic [BW-1:0] busy_cnt_nxt_s;
  logic          busy_r;
  logic          busy_nxt_s;

  // Retriggerable busy window; drops the cen cycle after the count hits zero
  always_comb begin
    if (bus.write) begin
      busy_nxt_s     = 1'b1;
      busy_cnt_nxt_s = BW'(BUSY_CYCLES - 1);
    end else if (busy_r) begin
      if (busy_cnt_r == '0) begin
        busy_nxt_s     = 1'b0;
        busy_cnt_nxt_s = busy_cnt_r;
      end else begin
        busy_nxt_s     = 1'b1;
        busy_cnt_nxt_s = busy_cnt_r - BW'(1);
      end
    end else begin
      busy_nxt_s     = 1'b0;
      busy_cnt_nxt_s = busy_cnt_r;
    end
  end

  // Busy registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy_r     <= 1'b0;
      busy_cnt_r <= '0;
    end else if (cen) begin
      busy_r     <= busy_nxt_s;
      busy_cnt_r <= busy_cnt_nxt_s;
    end else begin
      busy_r     <= busy_r;
      busy_cnt_r <= busy_cnt_r;
    end
  end

  assign bus.busy = busy_r;
`else
  logic unused_s;
  assign unused_s = bus.write ^ (BUSY_CYCLES == 32'sd0);
  assign bus.busy = 1'b0;
`endif

endmodule

// File: tb/tb_jt12_timer_flags.sv
// Directed bench for jt12_timer_flags: expectations are queued before each step and
// popped against the DUT after the step's clock edge.
module tb_jt12_timer_flags;

  logic clk;
  logic rst_n;
  logic cen;
  logic zero;

  jt12_timer_flags_if bus();

  jt12_timer_flags #(.TB_DIV(16), .BUSY_CYCLES(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .cen   (cen),
    .zero  (zero),
    .bus   (bus)
  );

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } sb_t;

  sb_t sb[$];
  int  n_chk  = 0;
  int  n_fail = 0;
  int  zcount = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic push(input string tag, input logic [31:0] exp);
    sb_t e;
    e.tag = tag;
    e.exp = exp;
    sb.push_back(e);
  endtask

  task automatic chk(input logic [31:0] obs);
    sb_t e;
    if (sb.size() == 0) begin
      n_fail++;
      $error("FAIL scoreboard_underflow: observed %0d expected <queued entry>", obs);
    end else begin
      e = sb.pop_front();
      n_chk++;
      assert (obs === e.exp) else begin
        n_fail++;
        $error("FAIL %s: observed %0d expected %0d", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse();
    zero = 1'b1;
    tick();
    zero = 1'b0;
    zcount++;
  endtask

  initial begin
    rst_n = 1'b0; cen = 1'b1; zero = 1'b0;
    bus.value_A = 10'd0; bus.value_B = 8'd0;
    bus.load_A = 1'b1; bus.load_B = 1'b1;
    bus.enable_irq_A = 1'b0; bus.enable_irq_B = 1'b0;
    bus.clr_flag_A = 1'b0; bus.clr_flag_B = 1'b0;
    bus.write = 1'b0;

    // Reset with loads high and zero toggling
    for (int i = 0; i < 4; i++) begin
      zero = (i % 2 == 1);
      tick();
    end
    push("rst_flag_A", 32'd0); push("rst_flag_B", 32'd0); push("rst_ovf_A", 32'd0);
    push("rst_busy", 32'd0);   push("rst_irq_n", 32'd1);  push("rst_cnt_A", 32'd0);
    push("rst_cnt_B", 32'd0);
    chk(32'(bus.flag_A)); chk(32'(bus.flag_B)); chk(32'(bus.overflow_A));
    chk(32'(bus.busy));   chk(32'(bus.irq_n));  chk(32'(dut.cnt_a_r));
    chk(32'(dut.cnt_b_r));

    rst_n = 1'b1; zero = 1'b0; bus.load_A = 1'b0; bus.load_B = 1'b0;
    tick();

    // Timer A from 1020 to overflow
    bus.value_A = 10'd1020; bus.enable_irq_A = 1'b1; bus.load_A = 1'b1;
    push("a_load_cnt", 32'd1020);
    tick();
    chk(32'(dut.cnt_a_r));
    for (int k = 1; k <= 3; k++) begin
      push("a_step_cnt", 32'(1020 + k)); push("a_step_ovf", 32'd0);
      pulse();
      chk(32'(dut.cnt_a_r)); chk(32'(bus.overflow_A));
    end
    push("a_ovf_pulse", 32'd1); push("a_ovf_reload", 32'd1020);
    push("a_ovf_flag", 32'd1);  push("a_irq_lag", 32'd1);
    pulse();
    chk(32'(bus.overflow_A)); chk(32'(dut.cnt_a_r)); chk(32'(bus.flag_A)); chk(32'(bus.irq_n));
    push("a_ovf_end", 32'd0); push("a_irq_low", 32'd0);
    tick();
    chk(32'(bus.overflow_A)); chk(32'(bus.irq_n));
    bus.clr_flag_A = 1'b1;
    push("a_clr_flag", 32'd0);
    tick();
    chk(32'(bus.flag_A));
    bus.clr_flag_A = 1'b0;
    push("a_irq_release", 32'd1);
    tick();
    chk(32'(bus.irq_n));

    // Set/clear collision: set wins, clear lands one cycle later
    for (int k = 0; k < 3; k++) pulse();
    bus.clr_flag_A = 1'b1;
    push("col_flag_set", 32'd1); push("col_ovf", 32'd1);
    pulse();
    chk(32'(bus.flag_A)); chk(32'(bus.overflow_A));
    push("col_flag_clr", 32'd0);
    tick();
    chk(32'(bus.flag_A));
    bus.clr_flag_A = 1'b0;

    // Overflow with IRQ disabled, then cen=0 holds the pulse
    bus.enable_irq_A = 1'b0;
    for (int k = 0; k < 3; k++) pulse();
    push("noirq_ovf", 32'd1); push("noirq_flag", 32'd0);
    pulse();
    chk(32'(bus.overflow_A)); chk(32'(bus.flag_A));
    cen = 1'b0; zero = 1'b1;
    push("cen0_ovf_hold", 32'd1); push("cen0_cnt_hold", 32'd1020);
    tick(); tick();
    chk(32'(bus.overflow_A)); chk(32'(dut.cnt_a_r));
    cen = 1'b1; zero = 1'b0;
    push("cen1_ovf_drop", 32'd0);
    tick();
    chk(32'(bus.overflow_A));

    // Load drop freezes the counter; next load edge reloads
    bus.value_A = 10'd500; bus.load_A = 1'b0;
    tick();
    bus.load_A = 1'b1;
    push("drop_load500", 32'd500);
    tick();
    chk(32'(dut.cnt_a_r));
    bus.load_A = 1'b0;
    push("drop_hold500", 32'd500);
    tick();
    for (int k = 0; k < 10; k++) pulse();
    chk(32'(dut.cnt_a_r));
    bus.value_A = 10'd777; bus.load_A = 1'b1;
    push("drop_reload", 32'd777);
    tick();
    chk(32'(dut.cnt_a_r));

    // Reload value 1023 overflows on every tick
    bus.load_A = 1'b0;
    tick();
    bus.value_A = 10'd1023; bus.load_A = 1'b1;
    push("max_load", 32'd1023);
    tick();
    chk(32'(dut.cnt_a_r));
    for (int k = 0; k < 2; k++) begin
      push("max_ovf", 32'd1); push("max_cnt", 32'd1023);
      pulse();
      chk(32'(bus.overflow_A)); chk(32'(dut.cnt_a_r));
    end

    // Timer B: align prescaler to 0, then 32 samples from 254
    bus.load_A = 1'b0;
    tick();
    while (zcount % 16 != 0) pulse();
    bus.value_B = 8'd254; bus.enable_irq_B = 1'b1; bus.load_B = 1'b1;
    push("b_load_cnt", 32'd254);
    tick();
    chk(32'(dut.cnt_b_r));
    for (int k = 1; k <= 32; k++) begin
      if (k == 16) push("b_cnt255", 32'd255);
      if (k == 31) push("b_flag_early", 32'd0);
      if (k == 32) begin
        push("b_flag_set", 32'd1); push("b_flag_A_quiet", 32'd0); push("b_reload", 32'd254);
      end
      pulse();
      if (k == 16) chk(32'(dut.cnt_b_r));
      if (k == 31) chk(32'(bus.flag_B));
      if (k == 32) begin
        chk(32'(bus.flag_B)); chk(32'(bus.flag_A)); chk(32'(dut.cnt_b_r));
      end
    end
    push("b_irq_low", 32'd0);
    tick();
    chk(32'(bus.irq_n));
    bus.clr_flag_B = 1'b1;
    push("b_clr_flag", 32'd0);
    tick();
    chk(32'(bus.flag_B));
    bus.clr_flag_B = 1'b0;

    // Write-busy generation
    bus.write = 1'b1;
`ifdef JT12_TIMER_BUSY_EN
    push("busy_set", 32'd1);
    tick();
    bus.write = 1'b0;
    chk(32'(bus.busy));
    for (int k = 0; k < 9; k++) tick();
    bus.write = 1'b1;
    tick();
    bus.write = 1'b0;
    for (int k = 0; k < 30; k++) tick();
    push("busy_t0p41", 32'd1);
    tick();
    chk(32'(bus.busy));
    push("busy_t0p42", 32'd0);
    tick();
    chk(32'(bus.busy));
`else
    push("busy_disabled", 32'd0);
    tick();
    bus.write = 1'b0;
    chk(32'(bus.busy));
`endif

    n_chk++;
    assert (sb.size() == 0) else begin
      n_fail++;
      $error("FAIL scoreboard_leftover: observed %0d expected 0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
